// File: rtl/seg7_frame_decoder.sv
// -----------------------------------------------------------------------------
// seg7_frame_decoder
//
// Purpose
//   Receives an 8-bit serial seven-segment frame (LSB first: a, b, c, d, e, f,
//   g, dp) and converts the segment pattern back into the value it displays.
//   The last good value and its decimal point are held on the outputs; a
//   pattern that does not correspond to any known glyph raises a sticky error.
//
// Parameters
//   SEG_ACTIVE_LOW : 1 -> every received bit (dp included) is inverted before
//                    it enters the shift register (common-anode sources).
//   HEX_EN         : 1 -> glyphs A, b, C, d, E, F decode to 0xA..0xF;
//                    0 -> those glyphs are reported as errors.
//
// Ports (packed into two byte-wide buses)
//   io_in[0]    clk    rising-edge clock, the only clock
//   io_in[1]    rst    asynchronous, active-high reset
//   io_in[2]    sdata  serial frame bit, sampled while en=1
//   io_in[3]    en     frame enable, held high for the whole frame
//   io_in[7:4]  -      unused, ignored
//   io_out[3:0] digit  last successfully decoded value
//   io_out[4]   dp     decimal point of the last good frame
//   io_out[5]   valid  one-cycle pulse per good frame
//   io_out[6]   err    set by an undecodable frame, cleared by a good one
//   io_out[7]   busy   high while a frame is in progress (SHIFT or DONE)
//
// Output protocol
//   There is no back-pressure. valid is a single-cycle strobe: it is high for
//   exactly the cycle after the DONE state of a good frame, and digit/dp are
//   already updated in that same cycle and stay stable until the next good
//   frame. A consumer that misses the strobe can still read digit/dp later.
//   Every output bit comes straight from a flop; nothing on io_in reaches
//   io_out combinationally.
// -----------------------------------------------------------------------------
module seg7_frame_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit HEX_EN         = 1'b1
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  // ---------------------------------------------------------------------------
  // Types
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // All receive-side state lives in one struct so a checker can bind to a
  // single signal (core_q) and see the FSM state, bit count and shift data.
  typedef struct packed {
    state_e     state;
    logic [3:0] count;
    logic [7:0] shift;
  } core_t;

  // ---------------------------------------------------------------------------
  // Input unpacking
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;
  logic sdata;
  logic en;
  logic bit_in;
  logic unused_io;

  assign clk   = io_in[0];
  assign rst   = io_in[1];
  assign sdata = io_in[2];
  assign en    = io_in[3];

  // Upper nibble is reserved; it is folded into a sink so it cannot
  // influence any logic.
  assign unused_io = ^io_in[7:4];

  // Polarity correction happens before the shift register, so the stored
  // frame is always in active-high form (dp included).
  assign bit_in = sdata ^ SEG_ACTIVE_LOW;

  // ---------------------------------------------------------------------------
  // Glyph decoder
  // Returns {ok, value}. Hex glyphs only report ok when HEX_EN is set.
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b0_0000;
    case (seg)
      7'h3F: res = {1'b1, 4'h0};
      7'h06: res = {1'b1, 4'h1};
      7'h5B: res = {1'b1, 4'h2};
      7'h4F: res = {1'b1, 4'h3};
      7'h66: res = {1'b1, 4'h4};
      7'h6D: res = {1'b1, 4'h5};
      7'h7D: res = {1'b1, 4'h6};
      7'h07: res = {1'b1, 4'h7};
      7'h7F: res = {1'b1, 4'h8};
      7'h6F: res = {1'b1, 4'h9};
      7'h77: res = {HEX_EN, 4'hA};
      7'h7C: res = {HEX_EN, 4'hB};
      7'h39: res = {HEX_EN, 4'hC};
      7'h5E: res = {HEX_EN, 4'hD};
      7'h79: res = {HEX_EN, 4'hE};
      7'h71: res = {HEX_EN, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  core_t      core_q;
  core_t      core_d;
  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       dp_q;
  logic       dp_d;
  logic       valid_q;
  logic       valid_d;
  logic       err_q;
  logic       err_d;
  logic       busy_q;
  logic       busy_d;

  // Decode is taken from the registered frame; it is only acted on in DONE,
  // when the shift register holds all eight bits.
  logic       dec_ok;
  logic [3:0] dec_digit;

  assign {dec_ok, dec_digit} = decode_seg(core_q.shift[6:0]);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    core_d  = core_q;
    digit_d = digit_q;
    dp_d    = dp_q;
    valid_d = 1'b0;
    err_d   = err_q;

    case (core_q.state)
      S_IDLE: begin
        if (en) begin
          // First bit of a frame; the shift register is rebuilt from scratch.
          core_d.shift = {bit_in, 7'b000_0000};
          core_d.count = 4'd1;
          core_d.state = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (en) begin
          // Bits arrive LSB first and enter at the top, so after eight
          // shifts bit0 of the frame sits in shift[0].
          core_d.shift = {bit_in, core_q.shift[7:1]};
          core_d.count = core_q.count + 4'd1;
          if (core_q.count == 4'd7) begin
            core_d.state = S_DONE;
          end
        end else begin
          // Abort: partial frame is dropped, result outputs untouched.
          core_d.shift = 8'h00;
          core_d.count = 4'd0;
          core_d.state = S_IDLE;
        end
      end

      S_DONE: begin
        if (dec_ok) begin
          digit_d = dec_digit;
          dp_d    = core_q.shift[7];
          valid_d = 1'b1;
          err_d   = 1'b0;
        end else begin
          err_d   = 1'b1;
        end

        // The frame has already been captured for decode above, so the
        // receiver can accept bit0 of the next frame in this same cycle.
        if (en) begin
          core_d.shift = {bit_in, 7'b000_0000};
          core_d.count = 4'd1;
          core_d.state = S_SHIFT;
        end else begin
          core_d.shift = 8'h00;
          core_d.count = 4'd0;
          core_d.state = S_IDLE;
        end
      end

      default: begin
        core_d.shift = 8'h00;
        core_d.count = 4'd0;
        core_d.state = S_IDLE;
      end
    endcase

    // busy is registered from the next state so it tracks the FSM exactly.
    busy_d = (core_d.state != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_q.state <= S_IDLE;
      core_q.count <= 4'd0;
      core_q.shift <= 8'h00;
      digit_q      <= 4'h0;
      dp_q         <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      core_q  <= core_d;
      digit_q <= digit_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  assign io_out = {busy_q, err_q, valid_q, dp_q, digit_q};

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_frame_decoder
//
// Three decoders run side by side on the same logical frame stream:
//   u_dut_hi   : SEG_ACTIVE_LOW=0, HEX_EN=1, fed the frame as-is
//   u_dut_lo   : SEG_ACTIVE_LOW=1, HEX_EN=1, fed the inverted frame
//   u_dut_lonh : SEG_ACTIVE_LOW=1, HEX_EN=0, fed the inverted frame
// The reference model works on whole frames: it collects received bits in a
// queue, and when eight have arrived it looks the segment pattern up in a
// glyph table and schedules the result for the following clock.
// -----------------------------------------------------------------------------
module tb_seg7_frame_decoder;

  // ---------------------------------------------------------------------------
  // Clock / reset / stimulus signals
  // ---------------------------------------------------------------------------
  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       en    = 1'b0;
  logic       sdata = 1'b0;
  logic [3:0] junk  = 4'h0;

  logic [7:0] in_hi;
  logic [7:0] in_lo;
  logic [7:0] out_hi;
  logic [7:0] out_lo;
  logic [7:0] out_lonh;

  assign in_hi = {junk, en, sdata,  rst, clk};
  assign in_lo = {junk, en, ~sdata, rst, clk};

  always #5 clk = ~clk;

  seg7_frame_decoder #(.SEG_ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_dut_hi (
    .io_in (in_hi),
    .io_out(out_hi)
  );

  seg7_frame_decoder #(.SEG_ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_dut_lo (
    .io_in (in_lo),
    .io_out(out_lo)
  );

  seg7_frame_decoder #(.SEG_ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_dut_lonh (
    .io_in (in_lo),
    .io_out(out_lonh)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Glyph table: index = displayed value.
  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       rx_bits [$];
  logic       pend;
  logic [7:0] pend_frame;
  logic [3:0] e_digit [3];
  logic       e_dp    [3];
  logic       e_valid [3];
  logic       e_err   [3];
  logic       e_busy;

  function automatic bit hex_of(int i);
    return (i != 2);
  endfunction

  // Returns the table index of a glyph, or -1 when it is not a usable glyph
  // for a decoder with the given hex setting.
  function automatic int lookup(input logic [6:0] seg, input bit hex);
    int r;
    r = -1;
    for (int k = 0; k < 16; k++) begin
      if (seg_tab[k] == seg && (k < 10 || hex)) r = k;
    end
    return r;
  endfunction

  function automatic void model_reset();
    rx_bits.delete();
    pend       = 1'b0;
    pend_frame = 8'h00;
    e_busy     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e_digit[i] = 4'h0;
      e_dp[i]    = 1'b0;
      e_valid[i] = 1'b0;
      e_err[i]   = 1'b0;
    end
  endfunction

  // One rising clock edge as seen by the model; b is the logical bit.
  function automatic void model_edge(input logic en_v, input logic b);
    int idx;
    for (int i = 0; i < 3; i++) e_valid[i] = 1'b0;
    if (pend) begin
      for (int i = 0; i < 3; i++) begin
        idx = lookup(pend_frame[6:0], hex_of(i));
        if (idx >= 0) begin
          e_digit[i] = 4'(idx);
          e_dp[i]    = pend_frame[7];
          e_valid[i] = 1'b1;
          e_err[i]   = 1'b0;
        end else begin
          e_err[i]   = 1'b1;
        end
      end
    end
    pend = 1'b0;
    if (en_v) begin
      rx_bits.push_back(b);
      if (rx_bits.size() == 8) begin
        for (int k = 0; k < 8; k++) pend_frame[k] = rx_bits[k];
        pend = 1'b1;
        rx_bits.delete();
      end
    end else begin
      rx_bits.delete();
    end
    e_busy = (rx_bits.size() != 0) || pend;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] out_of(int i);
    case (i)
      0:       return out_hi;
      1:       return out_lo;
      default: return out_lonh;
    endcase
  endfunction

  task automatic chk(input string tag, input int i,
                     input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h at t=%0t",
             tag, i, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string where);
    logic [7:0] o;
    for (int i = 0; i < 3; i++) begin
      o = out_of(i);
      chk({where, "/digit"}, i, o[3:0], e_digit[i]);
      chk({where, "/dp"},    i, {3'b000, o[4]}, {3'b000, e_dp[i]});
      chk({where, "/valid"}, i, {3'b000, o[5]}, {3'b000, e_valid[i]});
      chk({where, "/err"},   i, {3'b000, o[6]}, {3'b000, e_err[i]});
      chk({where, "/busy"},  i, {3'b000, o[7]}, {3'b000, e_busy});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic step(input logic en_v, input logic b, input string where);
    en    = en_v;
    sdata = b;
    junk  = 4'($urandom_range(0, 15));
    @(posedge clk);
    model_edge(en_v, b);
    @(negedge clk);
    check_all(where);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'($urandom_range(0, 1)), "idle");
  endtask

  task automatic send_bits(input logic [7:0] f, input int nbits, input string where);
    for (int k = 0; k < nbits; k++) step(1'b1, f[k], where);
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] f;
    int         gap;
    int         cut;

    model_reset();
    #1 rst = 1'b1;
    #1 check_all("reset");
    @(negedge clk);
    check_all("reset_hold");
    rst = 1'b0;
    idle(2);

    // Single frame "3"
    send_bits(8'h4F, 8, "f_4F");
    idle(3);

    // Back-to-back "0." then "1", no gap cycle
    send_bits(8'hBF, 8, "f_BF");
    send_bits(8'h06, 8, "f_06");
    idle(3);

    // Good "2", undecodable frame, then "8" clears the error
    send_bits(8'h5B, 8, "f_5B");
    idle(2);
    send_bits(8'h49, 8, "f_49");
    idle(3);
    send_bits(8'h7F, 8, "f_7F");
    idle(2);

    // All-zero pattern is an error too
    send_bits(8'h00, 8, "f_00");
    idle(2);

    // Abort after 5 bits, then a full "4"
    send_bits(8'h7D, 5, "abort");
    step(1'b0, 1'b0, "abort_drop");
    idle(1);
    send_bits(8'h66, 8, "f_66");
    idle(2);

    // Asynchronous reset while bit 4 of "6" is on the line
    send_bits(8'h7D, 4, "f_7D_part");
    en    = 1'b1;
    sdata = 1'b1;
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_all("async_rst_hold");
    rst = 1'b0;
    en  = 1'b0;
    idle(1);
    send_bits(8'h6D, 8, "f_6D");
    idle(2);

    // Hex glyph "A" (physically 0x88 on the active-low decoders)
    send_bits(8'h77, 8, "f_77");
    idle(2);
    // Hex glyph with dp, directly followed by a decimal digit
    send_bits(8'hF1, 8, "f_F1");
    send_bits(8'h07, 8, "f_07");
    idle(2);

    // Randomized frames, gaps and aborts
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        f = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
      end else begin
        f = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 5) == 0) begin
        cut = $urandom_range(1, 7);
        send_bits(f, cut, "rnd_abort");
        step(1'b0, 1'b0, "rnd_abort_drop");
      end else begin
        send_bits(f, 8, "rnd_frame");
      end
      gap = $urandom_range(0, 2);
      idle(gap);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
